ksa: RTL

- RC4 key-scheduling stage; sits directly upstream of prga, downstream of init (which leaves S[i]=i).
- Permutes the shared 256x8 S memory in place using a variable-length secret key.
- Hands prga a scheduled S array. Uses the same en/rdy handshake as the rest of the task chain.

---
 rtl/rc4_pkg.sv | 32 +++
 rtl/ksa.sv | 132 +++++++++++++
 2 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions for the task chain (init -> ksa -> prga).
// Provides the KSA state encoding, S array size, default key length and
// the key-byte selector used by the key-scheduling datapath.
package rc4_pkg;

  localparam int unsigned S_SIZE            = 256;
  localparam int unsigned DEFAULT_KEY_BYTES = 3;
  // Widest key the byte selector accepts; callers zero-extend narrower keys.
  localparam int unsigned KEY_MAX_BYTES     = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    WT_I,
    RD_J,
    WT_J,
    WR_I,
    WR_J
  } ksa_state_t;

  // Byte k of an nbytes-long key, byte 0 being the most significant byte.
  function automatic logic [7:0] key_byte(
    input logic [8*KEY_MAX_BYTES-1:0] key,
    input int unsigned                nbytes,
    input logic [7:0]                 k
  );
    int unsigned idx;
    idx = nbytes - 1 - 32'(k);
    return key[8*idx +: 8];
  endfunction

endpackage

// File: rtl/ksa.sv
// RC4 key-scheduling stage. Permutes the shared 256x8 S memory in place:
// for i = 0..255: j = j + S[i] + key[i mod KEY_BYTES]; swap S[i], S[j].
// Six cycles per iteration against a synchronous-read RAM.
//
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   en      - start request, sampled only while rdy = 1
//   rdy     - 1 = idle, able to accept en
//   key     - secret key, byte 0 in the most significant byte
//   addr    - S memory address
//   rddata  - S memory read data, valid one cycle after addr
//   wrdata  - S memory write data
//   wren    - S memory write enable
module ksa
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_BYTES = DEFAULT_KEY_BYTES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren
);

  ksa_state_t state_q, state_d;

  logic [8*KEY_BYTES-1:0]   key_q;
  logic [8*KEY_MAX_BYTES-1:0] key_ext;
  logic [7:0] i_q, j_q, k_q, si_q, sj_q;
  logic [7:0] kb;

  always_comb begin
    key_ext                  = '0;
    key_ext[8*KEY_BYTES-1:0] = key_q;
    kb                       = key_byte(key_ext, KEY_BYTES, k_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode from state and registers only; rddata never reaches
  // addr/wren combinationally.
  always_comb begin
    state_d = state_q;
    addr    = '0;
    wrdata  = '0;
    wren    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = RD_I;
      end
      RD_I: begin
        addr    = i_q;
        state_d = WT_I;
      end
      WT_I: begin
        addr    = i_q;
        state_d = RD_J;
      end
      RD_J: begin
        addr    = j_q;
        state_d = WT_J;
      end
      WT_J: begin
        addr    = j_q;
        state_d = WR_I;
      end
      WR_I: begin
        addr    = i_q;
        wrdata  = sj_q;
        wren    = 1'b1;
        state_d = WR_J;
      end
      WR_J: begin
        addr    = j_q;
        wrdata  = si_q;
        wren    = 1'b1;
        state_d = (i_q == 8'hFF) ? IDLE : RD_I;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdy = (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
      si_q  <= '0;
      sj_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            key_q <= key;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
          end
        end
        WT_I: begin
          si_q <= rddata;
          j_q  <= j_q + rddata + kb;
        end
        WT_J: begin
          sj_q <= rddata;
        end
        WR_J: begin
          // i wraps 255 -> 0 on the final iteration; it is cleared on start anyway.
          i_q <= i_q + 8'd1;
          k_q <= (k_q == 8'(KEY_BYTES - 1)) ? 8'd0 : k_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
